// File: rtl/fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO.
package fifo_pkg;

  typedef enum logic {
    MODE_STANDARD,
    MODE_SHOW_AHEAD
  } read_mode_e;

  // Wraps explicitly at depth-1 so non-power-of-two depths never use the unused address range.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/generic_ram_fifo_if.sv
// FIFO request/response bundle: the producer/consumer side is master, the FIFO is slave.
interface generic_ram_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 400
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              write;
  logic [DATA_W-1:0] w_data;
  logic              read;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              flush;
  logic              clear_flags;
  logic [CntW-1:0]   count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output write, w_data, read, flush, clear_flags,
    input  r_data, r_valid, count, empty, full, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write, w_data, read, flush, clear_flags,
    output r_data, r_valid, count, empty, full, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port with 1-cycle latency.
module fifo_ram_dp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 400,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] write_address_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] read_address_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // q_o only changes on re_i; the show-ahead head word relies on that hold.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[write_address_i] <= data_i;
    if (re_i) q_o <= mem_q[read_address_i];
  end

endmodule

// File: rtl/generic_ram_fifo.sv
// Parametrised block-RAM FIFO with occupancy, threshold and sticky error flags,
// and either standard (registered-read) or show-ahead output timing.
module generic_ram_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 400,
  parameter int unsigned AFULL_LVL  = DEPTH - 4,
  parameter int unsigned AEMPTY_LVL = 4,
  parameter int unsigned SHOW_AHEAD = 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  generic_ram_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CntW   = ADDR_W + 1;
  localparam read_mode_e  Mode   = (SHOW_AHEAD != 0) ? MODE_SHOW_AHEAD : MODE_STANDARD;

  localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt  = CntW'(AFULL_LVL);
  localparam logic [CntW-1:0] AemptyCnt = CntW'(AEMPTY_LVL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              afull_q, afull_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  // Standard mode: r_valid pulse. Show-ahead mode: RAM output register holds the head word.
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] ram_q;
  logic              wr_ok, rd_ok, re;

  always_comb begin
    wr_ok = bus.write & ~full_q & ~bus.flush;
    rd_ok = bus.read & ~empty_q & ~bus.flush;

    if (Mode == MODE_SHOW_AHEAD) begin
      // Refill the head when it is free or being popped and a word sits in RAM behind it.
      re    = ~bus.flush & (count_q != {{(CntW-1){1'b0}}, vld_q}) & (~vld_q | rd_ok);
      vld_d = ~bus.flush & (re | (vld_q & ~rd_ok));
    end else begin
      re    = rd_ok;
      vld_d = rd_ok;
    end

    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ADDR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
      if (re)    rd_ptr_d = ADDR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
    end

    empty_d  = (Mode == MODE_SHOW_AHEAD) ? ~vld_d : (count_d == '0);
    full_d   = (count_d == DepthCnt);
    afull_d  = (count_d >= AfullCnt);
    aempty_d = (count_d <= AemptyCnt);

    // A violation in the same cycle as clear_flags keeps the flag set.
    ovf_d = (ovf_q & ~bus.clear_flags) | (bus.write & full_q & ~bus.flush);
    udf_d = (udf_q & ~bus.clear_flags) | (bus.read & empty_q & ~bus.flush);

    hold_d = (Mode == MODE_STANDARD && vld_q) ? ram_q : hold_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
      hold_q   <= hold_d;
    end
  end

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i           (clk_i),
    .we_i            (wr_ok),
    .write_address_i (wr_ptr_q),
    .data_i          (bus.w_data),
    .read_address_i  (rd_ptr_q),
    .re_i            (re),
    .q_o             (ram_q)
  );

  assign bus.r_data       = vld_q ? ram_q : hold_q;
  assign bus.r_valid      = vld_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_generic_ram_fifo.sv
// Drives three FIFO configurations with one stimulus stream and checks each against a queue model.
module tb_generic_ram_fifo;

  logic       clk;
  logic       rst_n;
  logic       t_write;
  logic [7:0] t_wdata;
  logic       t_read;
  logic       t_flush;
  logic       t_clear;

  int vectors;
  int miscompares;

  // Model state per instance: 0 = depth 8 standard, 1 = depth 6 standard, 2 = depth 6 show-ahead.
  int         dep   [3] = '{8, 6, 6};
  bit         sa    [3] = '{1'b0, 1'b0, 1'b1};
  string      nm    [3] = '{"std8", "std6", "sa6"};
  logic [7:0] mq    [3][$];
  bit         ovf   [3];
  bit         udf   [3];
  bit         shown [3];
  bit         rv    [3];
  logic [7:0] hold  [3];

  generic_ram_fifo_if #(.DATA_W(8), .DEPTH(8)) bus0 ();
  generic_ram_fifo_if #(.DATA_W(8), .DEPTH(6)) bus1 ();
  generic_ram_fifo_if #(.DATA_W(8), .DEPTH(6)) bus2 ();

  assign bus0.write = t_write;  assign bus0.w_data = t_wdata;  assign bus0.read = t_read;
  assign bus0.flush = t_flush;  assign bus0.clear_flags = t_clear;
  assign bus1.write = t_write;  assign bus1.w_data = t_wdata;  assign bus1.read = t_read;
  assign bus1.flush = t_flush;  assign bus1.clear_flags = t_clear;
  assign bus2.write = t_write;  assign bus2.w_data = t_wdata;  assign bus2.read = t_read;
  assign bus2.flush = t_flush;  assign bus2.clear_flags = t_clear;

  generic_ram_fifo #(.DATA_W(8), .DEPTH(8), .SHOW_AHEAD(0)) u_std8 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0)
  );
  generic_ram_fifo #(.DATA_W(8), .DEPTH(6), .SHOW_AHEAD(0)) u_std6 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
  );
  generic_ram_fifo #(.DATA_W(8), .DEPTH(6), .SHOW_AHEAD(1)) u_sa6 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      ovf[i]   = 1'b0;
      udf[i]   = 1'b0;
      shown[i] = 1'b0;
      rv[i]    = 1'b0;
      hold[i]  = 8'h00;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int         n;
      bit         is_full, is_empty, wok, rok;
      logic [7:0] popped;
      n        = mq[i].size();
      is_full  = (n == dep[i]);
      is_empty = sa[i] ? !shown[i] : (n == 0);
      wok      = t_write && !is_full && !t_flush;
      rok      = t_read && !is_empty && !t_flush;
      ovf[i]   = (ovf[i] && !t_clear) || (t_write && is_full && !t_flush);
      udf[i]   = (udf[i] && !t_clear) || (t_read && is_empty && !t_flush);
      if (t_flush) begin
        mq[i].delete();
        shown[i] = 1'b0;
        rv[i]    = 1'b0;
      end else begin
        // Show-ahead head becomes visible once a word written before this edge remains.
        if (sa[i]) shown[i] = (n - int'(rok)) > 0;
        else       rv[i] = rok;
        if (rok) begin
          popped = mq[i].pop_front();
          if (!sa[i]) hold[i] = popped;
        end
        if (wok) mq[i].push_back(t_wdata);
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] cnt, input logic emp, input logic fl,
                            input logic af, input logic ae, input logic ov, input logic ud,
                            input logic rvo, input logic [7:0] rd);
    int         n;
    bit         vis;
    logic [7:0] exp_rd;
    n      = mq[i].size();
    vis    = sa[i] ? shown[i] : (n != 0);
    exp_rd = sa[i] ? (shown[i] ? mq[i][0] : 8'h00) : hold[i];
    chk({nm[i], " count"}, 32'(cnt), n);
    chk({nm[i], " empty"}, 32'(emp), 32'(!vis));
    chk({nm[i], " full"}, 32'(fl), 32'(n == dep[i]));
    chk({nm[i], " almost_full"}, 32'(af), 32'(n >= dep[i] - 4));
    chk({nm[i], " almost_empty"}, 32'(ae), 32'(n <= 4));
    chk({nm[i], " overflow"}, 32'(ov), 32'(ovf[i]));
    chk({nm[i], " underflow"}, 32'(ud), 32'(udf[i]));
    chk({nm[i], " r_valid"}, 32'(rvo), 32'(sa[i] ? shown[i] : rv[i]));
    chk({nm[i], " r_data"}, 32'(rd), 32'(exp_rd));
  endtask

  task automatic check_all();
    check_inst(0, bus0.count, bus0.empty, bus0.full, bus0.almost_full, bus0.almost_empty,
               bus0.overflow, bus0.underflow, bus0.r_valid, bus0.r_data);
    check_inst(1, bus1.count, bus1.empty, bus1.full, bus1.almost_full, bus1.almost_empty,
               bus1.overflow, bus1.underflow, bus1.r_valid, bus1.r_data);
    check_inst(2, bus2.count, bus2.empty, bus2.full, bus2.almost_full, bus2.almost_empty,
               bus2.overflow, bus2.underflow, bus2.r_valid, bus2.r_data);
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check at the next fall.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic f,
                       input logic c);
    t_write = w;
    t_wdata = d;
    t_read  = r;
    t_flush = f;
    t_clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    t_write = 1'b0; t_wdata = 8'h00; t_read = 1'b0; t_flush = 1'b0; t_clear = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x11..0x88; the depth-6 instances overflow on the last two.
    for (int k = 1; k <= 8; k++) cycle(1'b1, 8'(k * 8'h11), 1'b0, 1'b0, 1'b0);
    // Full with simultaneous read and write: read wins, write dropped, overflow set.
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // Drain, then one extra idle edge to see the last r_valid pulse end.
    for (int k = 0; k < 8; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Empty with simultaneous read and write: write accepted, underflow set.
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Wrap: prime one word, then 20 simultaneous write/read pairs.
    cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) cycle(1'b1, 8'(8'h20 + k), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Five words queued, then read held high for five cycles.
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Three words then flush alongside a write of 0x77.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'hD0 + k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset asserted in the middle of a write burst, between clock edges.
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'hE0 + k), k[0], 1'b0, 1'b0);
    t_write = 1'b1;
    t_wdata = 8'hE9;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    t_write = 1'b0;
    rst_n   = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomised traffic alternating write-heavy and read-heavy phases.
    for (int k = 0; k < 600; k++) begin
      int wp;
      wp = ((k / 75) % 2 == 0) ? 7 : 3;
      cycle($urandom_range(0, 9) < wp, 8'($urandom), $urandom_range(0, 9) < (10 - wp),
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
